// File: rtl/access_controller_param.sv
// access_controller_param: keypad access controller with a parameterised digit
// width and digit count, a checker handshake, failed-password lockout, and
// reconfig abort.
// Optional build macro ENTRY_TIMEOUT_EN adds an inactivity timeout to the
// digit-entry states.
module access_controller_param #(
    parameter int DIGIT_W        = 4,
    parameter int ID_DIGITS      = 4,
    parameter int PWD_DIGITS     = 4,
    parameter int MAX_TRIES      = 3,
    parameter int LOCK_CYCLES    = 1000,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DIGIT_W-1:0]                digit_in,
    input  logic                              enter_btn,
    input  logic                              next_btn,
    input  logic                              reconfig_btn,
    input  logic                              start_timer,
    input  logic                              check_done,
    input  logic                              check_ok,
    output logic [ID_DIGITS*DIGIT_W-1:0]      id_bus,
    output logic [PWD_DIGITS*DIGIT_W-1:0]     pwd_bus,
    output logic                              id_valid,
    output logic                              pwd_valid,
    output logic                              timer_en,
    output logic                              enter_access,
    output logic                              next_access,
    output logic                              green_led,
    output logic                              id_led,
    output logic                              lock_led,
    output logic [$clog2(MAX_TRIES+1)-1:0]    fail_count
);
    typedef enum logic [2:0] {
        IDLE, GET_ID, WAIT_ID, GET_PWD, WAIT_PWD, GRANTED, ACTIVE, LOCKED
    } state_t;

    localparam int MAXD = (ID_DIGITS > PWD_DIGITS) ? ID_DIGITS : PWD_DIGITS;
    localparam int KW   = $clog2(MAXD + 1);
    localparam int FW   = $clog2(MAX_TRIES + 1);
    // One counter serves the lockout (LOCKED) and the entry timeout (GET_*);
    // the two never run at the same time, so the width covers both.
    localparam int CMAX = (LOCK_CYCLES > TIMEOUT_CYCLES) ? LOCK_CYCLES : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    state_t                          state, state_n;
    logic [KW-1:0]                   k, k_n;
    logic [CW-1:0]                   cnt, cnt_n;
    logic [ID_DIGITS*DIGIT_W-1:0]    id_bus_n;
    logic [PWD_DIGITS*DIGIT_W-1:0]   pwd_bus_n;
    logic                            id_valid_n, pwd_valid_n, timer_en_n;
    logic                            enter_n, next_n, green_n, id_led_n, lock_led_n;
    logic [FW-1:0]                   fail_n;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_n     = state;
        k_n         = k;
        cnt_n       = '0;
        id_bus_n    = id_bus;
        pwd_bus_n   = pwd_bus;
        id_valid_n  = id_valid;
        pwd_valid_n = pwd_valid;
        timer_en_n  = timer_en;
        green_n     = green_led;
        id_led_n    = id_led;
        lock_led_n  = lock_led;
        fail_n      = fail_count;
        enter_n     = 1'b0;
        next_n      = 1'b0;
        if (reconfig_btn && state != IDLE && state != LOCKED) begin
            // Abort outranks digits, checker strobes and start_timer.
            state_n     = IDLE;
            id_valid_n  = 1'b0;
            pwd_valid_n = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    id_bus_n   = '0;
                    pwd_bus_n  = '0;
                    k_n        = '0;
                    id_led_n   = 1'b0;
                    green_n    = 1'b0;
                    timer_en_n = 1'b0;
                    state_n    = GET_ID;
                end
                GET_ID: begin
                    if (enter_btn) begin
                        // First digit lands in the most significant slot.
                        for (int i = 0; i < ID_DIGITS; i++)
                            if (k == KW'(i))
                                id_bus_n[(ID_DIGITS-1-i)*DIGIT_W +: DIGIT_W] = digit_in;
                        if (k == KW'(ID_DIGITS-1)) begin
                            k_n        = '0;
                            id_valid_n = 1'b1;
                            state_n    = WAIT_ID;
                        end else begin
                            k_n = k + 1'b1;
                        end
                    end
`ifdef ENTRY_TIMEOUT_EN
                    else if (cnt == CW'(TIMEOUT_CYCLES-1)) state_n = IDLE;
                    else cnt_n = cnt + 1'b1;
`endif
                end
                WAIT_ID: begin
                    if (check_done) begin
                        id_valid_n = 1'b0;
                        if (check_ok) begin
                            id_led_n = 1'b1;
                            state_n  = GET_PWD;
                        end else begin
                            state_n  = IDLE;
                        end
                    end
                end
                GET_PWD: begin
                    if (enter_btn) begin
                        for (int i = 0; i < PWD_DIGITS; i++)
                            if (k == KW'(i))
                                pwd_bus_n[(PWD_DIGITS-1-i)*DIGIT_W +: DIGIT_W] = digit_in;
                        if (k == KW'(PWD_DIGITS-1)) begin
                            k_n         = '0;
                            pwd_valid_n = 1'b1;
                            state_n     = WAIT_PWD;
                        end else begin
                            k_n = k + 1'b1;
                        end
                    end
`ifdef ENTRY_TIMEOUT_EN
                    else if (cnt == CW'(TIMEOUT_CYCLES-1)) begin
                        id_led_n = 1'b0;
                        state_n  = IDLE;
                    end else cnt_n = cnt + 1'b1;
`endif
                end
                WAIT_PWD: begin
                    if (check_done) begin
                        pwd_valid_n = 1'b0;
                        if (check_ok) begin
                            green_n = 1'b1;
                            fail_n  = '0;
                            state_n = GRANTED;
                        end else if (int'(fail_count) + 1 < MAX_TRIES) begin
                            fail_n    = fail_count + 1'b1;
                            pwd_bus_n = '0;
                            state_n   = GET_PWD;
                        end else begin
                            fail_n     = fail_count + 1'b1;
                            lock_led_n = 1'b1;
                            cnt_n      = CW'(LOCK_CYCLES-1);
                            state_n    = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    // Deaf to every input until the count runs out.
                    if (cnt == '0) begin
                        lock_led_n = 1'b0;
                        fail_n     = '0;
                        state_n    = IDLE;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                GRANTED: begin
                    if (start_timer) begin
                        timer_en_n = 1'b1;
                        state_n    = ACTIVE;
                    end
                end
                ACTIVE: begin
                    enter_n = enter_btn;
                    next_n  = next_btn;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            k            <= '0;
            cnt          <= '0;
            id_bus       <= '0;
            pwd_bus      <= '0;
            id_valid     <= 1'b0;
            pwd_valid    <= 1'b0;
            timer_en     <= 1'b0;
            enter_access <= 1'b0;
            next_access  <= 1'b0;
            green_led    <= 1'b0;
            id_led       <= 1'b0;
            lock_led     <= 1'b0;
            fail_count   <= '0;
        end else begin
            state        <= state_n;
            k            <= k_n;
            cnt          <= cnt_n;
            id_bus       <= id_bus_n;
            pwd_bus      <= pwd_bus_n;
            id_valid     <= id_valid_n;
            pwd_valid    <= pwd_valid_n;
            timer_en     <= timer_en_n;
            enter_access <= enter_n;
            next_access  <= next_n;
            green_led    <= green_n;
            id_led       <= id_led_n;
            lock_led     <= lock_led_n;
            fail_count   <= fail_n;
        end
    end
endmodule

// File: tb/tb_access_controller_param.sv
// Bench for access_controller_param: directed scenarios with literal
// expectations plus a randomized run, all checked every cycle against a
// digit-array reference model.
module tb_access_controller_param;
    localparam int DW = 4, NI = 4, NP = 4, MT = 3, LC = 10, TC = 20;
`ifdef ENTRY_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1;
    logic [DW-1:0] digit_in = '0;
    logic enter_btn = 0, next_btn = 0, reconfig_btn = 0, start_timer = 0;
    logic check_done = 0, check_ok = 0;
    logic [NI*DW-1:0] id_bus;
    logic [NP*DW-1:0] pwd_bus;
    logic id_valid, pwd_valid, timer_en, enter_access, next_access;
    logic green_led, id_led, lock_led;
    logic [1:0] fail_count;

    access_controller_param #(
        .DIGIT_W(DW), .ID_DIGITS(NI), .PWD_DIGITS(NP), .MAX_TRIES(MT),
        .LOCK_CYCLES(LC), .TIMEOUT_CYCLES(TC)
    ) dut (
        .clk(clk), .rst(rst), .digit_in(digit_in), .enter_btn(enter_btn),
        .next_btn(next_btn), .reconfig_btn(reconfig_btn), .start_timer(start_timer),
        .check_done(check_done), .check_ok(check_ok), .id_bus(id_bus),
        .pwd_bus(pwd_bus), .id_valid(id_valid), .pwd_valid(pwd_valid),
        .timer_en(timer_en), .enter_access(enter_access), .next_access(next_access),
        .green_led(green_led), .id_led(id_led), .lock_led(lock_led),
        .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase of the session, digits held as arrays, plain counters.
    localparam int P_IDLE = 0, P_ID = 1, P_WID = 2, P_PWD = 3, P_WPWD = 4,
                   P_GR = 5, P_ACT = 6, P_LOCK = 7;
    int ph = P_IDLE, pos = 0, tries = 0, lock_left = 0, idle_run = 0;
    logic [DW-1:0] m_id [NI];
    logic [DW-1:0] m_pw [NP];
    bit e_idv, e_pwv, e_tim, e_ea, e_na, e_grn, e_idl, e_lck;

    function automatic logic [NI*DW-1:0] pack_id();
        logic [NI*DW-1:0] r;
        for (int i = 0; i < NI; i++) r[(NI-1-i)*DW +: DW] = m_id[i];
        return r;
    endfunction

    function automatic logic [NP*DW-1:0] pack_pw();
        logic [NP*DW-1:0] r;
        for (int i = 0; i < NP; i++) r[(NP-1-i)*DW +: DW] = m_pw[i];
        return r;
    endfunction

    task automatic clear_digits();
        for (int i = 0; i < NI; i++) m_id[i] = '0;
        for (int i = 0; i < NP; i++) m_pw[i] = '0;
    endtask

    task automatic model_step();
        bit abort;
        if (rst) begin
            ph = P_IDLE; pos = 0; tries = 0; lock_left = 0; idle_run = 0;
            clear_digits();
            {e_idv, e_pwv, e_tim, e_ea, e_na, e_grn, e_idl, e_lck} = '0;
            return;
        end
        e_ea = (ph == P_ACT && !reconfig_btn) ? enter_btn : 1'b0;
        e_na = (ph == P_ACT && !reconfig_btn) ? next_btn  : 1'b0;
        abort = reconfig_btn && ph != P_IDLE && ph != P_LOCK;
        if (abort) begin
            ph = P_IDLE; e_idv = 0; e_pwv = 0;
        end else begin
            case (ph)
                P_IDLE: begin
                    clear_digits(); pos = 0;
                    e_idl = 0; e_grn = 0; e_tim = 0; ph = P_ID;
                end
                P_ID, P_PWD: begin
                    if (enter_btn) begin
                        if (ph == P_ID) m_id[pos] = digit_in; else m_pw[pos] = digit_in;
                        pos++; idle_run = 0;
                        if (ph == P_ID && pos == NI) begin pos = 0; e_idv = 1; ph = P_WID; end
                        else if (ph == P_PWD && pos == NP) begin pos = 0; e_pwv = 1; ph = P_WPWD; end
                    end else if (TMO_ON) begin
                        idle_run++;
                        if (idle_run == TC) begin
                            if (ph == P_PWD) e_idl = 0;
                            ph = P_IDLE;
                        end
                    end
                end
                P_WID: if (check_done) begin
                    e_idv = 0;
                    if (check_ok) begin e_idl = 1; ph = P_PWD; end else ph = P_IDLE;
                end
                P_WPWD: if (check_done) begin
                    e_pwv = 0;
                    if (check_ok) begin e_grn = 1; tries = 0; ph = P_GR; end
                    else begin
                        tries++;
                        if (tries < MT) begin
                            for (int i = 0; i < NP; i++) m_pw[i] = '0;
                            ph = P_PWD;
                        end else begin
                            e_lck = 1; lock_left = LC; ph = P_LOCK;
                        end
                    end
                end
                P_LOCK: begin
                    lock_left--;
                    if (lock_left == 0) begin e_lck = 0; tries = 0; ph = P_IDLE; end
                end
                P_GR: if (start_timer) begin e_tim = 1; ph = P_ACT; end
                default: ;
            endcase
        end
        if (ph != P_ID && ph != P_PWD) idle_run = 0;
    endtask

    // Single compare process: step the model on each edge, check all outputs just after.
    always @(posedge clk) begin
        model_step();
        #1;
        chk("id_bus", id_bus, pack_id());
        chk("pwd_bus", pwd_bus, pack_pw());
        chk("id_valid", id_valid, e_idv);
        chk("pwd_valid", pwd_valid, e_pwv);
        chk("timer_en", timer_en, e_tim);
        chk("enter_access", enter_access, e_ea);
        chk("next_access", next_access, e_na);
        chk("green_led", green_led, e_grn);
        chk("id_led", id_led, e_idl);
        chk("lock_led", lock_led, e_lck);
        chk("fail_count", fail_count, tries);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [DW-1:0] d);
        digit_in = d; enter_btn = 1; @(negedge clk); enter_btn = 0;
    endtask

    task automatic done(input bit ok);
        check_done = 1; check_ok = ok; @(negedge clk); check_done = 0; check_ok = 0;
    endtask

    task automatic do_reset();
        rst = 1; idle(2); rst = 0; idle(1);
    endtask

    task automatic enter4(input logic [15:0] v);
        for (int i = 0; i < 4; i++) begin
            logic [15:0] t;
            t = v << (4 * i);
            press(t[15:12]);
        end
    endtask

    initial begin
        int n;
        // Reset state
        idle(2);
        chk("rst_id_bus", id_bus, 0);
        chk("rst_leds", {green_led, id_led, lock_led, timer_en}, 0);
        chk("rst_valids", {id_valid, pwd_valid, enter_access, next_access}, 0);
        chk("rst_fail", fail_count, 0);
        rst = 0; idle(1);

        // Happy path
        enter4(16'h1234);
        chk("hp_id_valid", id_valid, 1);
        chk("hp_id_bus", id_bus, 16'h1234);
        done(1);
        chk("hp_id_led", id_led, 1);
        chk("hp_id_valid_drop", id_valid, 0);
        enter4(16'h5678);
        chk("hp_pwd_valid", pwd_valid, 1);
        done(1);
        chk("hp_pwd_bus", pwd_bus, 16'h5678);
        chk("hp_green", green_led, 1);
        start_timer = 1; @(negedge clk); start_timer = 0;
        chk("hp_timer_en", timer_en, 1);
        enter_btn = 1; @(negedge clk); enter_btn = 0;
        chk("hp_enter_access_hi", enter_access, 1);
        @(negedge clk);
        chk("hp_enter_access_lo", enter_access, 0);

        // Three rejections then lockout
        do_reset();
        enter4(16'h1111); done(1);
        for (int t = 1; t <= 3; t++) begin
            enter4(16'h9999); done(0);
            chk("lk_fail_count", fail_count, t);
            if (t < 3) chk("lk_pwd_cleared", pwd_bus, 0);
        end
        chk("lk_lock_led", lock_led, 1);
        reconfig_btn = 1; enter_btn = 1;
        n = 0;
        for (int c = 0; c < 40 && lock_led === 1'b1; c++) begin
            n++; @(negedge clk);
        end
        reconfig_btn = 0; enter_btn = 0;
        chk("lk_dwell", n, LC);
        chk("lk_fail_cleared", fail_count, 0);

        // Two rejections then accept
        do_reset();
        enter4(16'h2222); done(1);
        enter4(16'h0001); done(0);
        enter4(16'h0002); done(0);
        chk("ra_fail2", fail_count, 2);
        enter4(16'h0003); done(1);
        chk("ra_fail0", fail_count, 0);
        chk("ra_green", green_led, 1);

        // ID rejected
        do_reset();
        enter4(16'hA53C);
        chk("ir_id_bus", id_bus, 16'hA53C);
        done(0);
        chk("ir_id_valid", id_valid, 0);
        chk("ir_id_led", id_led, 0);
        idle(1);
        chk("ir_idle_cleared", id_bus, 0);

        // reconfig with the last password digit
        do_reset();
        enter4(16'h4321); done(1);
        press(1); press(2); press(3);
        reconfig_btn = 1; press(4); reconfig_btn = 0;
        chk("rc_pwd_valid", pwd_valid, 0);
        idle(1);
        chk("rc_idle_id_led", id_led, 0);
        chk("rc_idle_pwd_bus", pwd_bus, 0);

        // Reset mid-ID
        do_reset();
        press(7); press(8);
        rst = 1; @(negedge clk);
        chk("mr_outputs", {id_bus, pwd_bus, id_valid, pwd_valid, id_led, green_led}, 0);
        rst = 0; idle(1);

`ifdef ENTRY_TIMEOUT_EN
        do_reset();
        press(1); press(2);
        idle(TC + 1);
        chk("to_id_cleared", id_bus, 0);
        press(3); press(4);
        idle(TC - 1);
        press(5); press(6);
        chk("to_continue_valid", id_valid, 1);
        chk("to_continue_bus", id_bus, 16'h3456);
`endif

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            digit_in     = DW'($urandom);
            enter_btn    = ($urandom_range(0, 99) < 40);
            next_btn     = ($urandom_range(0, 99) < 30);
            reconfig_btn = ($urandom_range(0, 199) < 3);
            start_timer  = ($urandom_range(0, 99) < 20);
            check_done   = ($urandom_range(0, 99) < 25);
            check_ok     = ($urandom_range(0, 2) != 0);
            rst          = ($urandom_range(0, 999) < 3);
            @(negedge clk);
        end
        {enter_btn, next_btn, reconfig_btn, start_timer, check_done, check_ok, rst} = '0;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
